uart_frame_serializer: RTL and testbench

- Downstream stage of the 44-bit UART frame tristate buffer.
- Accepts one 44-bit frame (4 UART characters of 11 bits: start, 8 data LSB first, parity, stop) and shifts it out bit-serially on a single TX line at the configured baud rate.
- Checks framing and parity of the frame as it is accepted, then drives the tx pin toward the serial adapter output.

---
 rtl/uart_frame_serializer.sv | 130 +++++++++++++
 tb/tb_uart_frame_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_serializer.sv
// Serializes one 44-bit UART frame (4 x 11-bit characters) onto a registered TX line.
// Framing and parity are checked per character at accept; optional idle guard time follows each frame.
module uart_frame_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int GUARD_BITS = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [43:0] i_frame_in,
    input  logic        i_load,
    input  logic        i_abort,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

    localparam logic [15:0] LP_BAUD_LAST  = 16'(CLK_DIV - 1);
    localparam logic [5:0]  LP_LAST_BIT   = 6'd43;
    localparam logic [5:0]  LP_GUARD_LAST = (GUARD_BITS > 0) ? 6'(GUARD_BITS - 1) : 6'd0;
    localparam logic        LP_PARITY     = (PARITY_ODD != 0);

    state_t      r_state;
    state_t      w_nextState;
    logic [43:0] r_shift;
    logic [5:0]  r_bitCnt;
    logic [15:0] r_baudCnt;
    logic [3:0]  r_frameErr;
    logic        r_done;
    logic        w_accept;
    logic        w_doneNext;
    logic        w_baudWrap;
    logic [3:0]  w_frameErr;

    assign w_baudWrap  = (r_baudCnt == LP_BAUD_LAST);
    assign o_ready     = (r_state == IDLE) && !i_abort;
    assign o_busy      = (r_state != IDLE);
    assign o_tx        = r_shift[0];
    assign o_done      = r_done;
    assign o_frame_err = r_frameErr;

    // Parity covers the 8 data bits plus the parity bit of each character.
    always_comb begin
        w_frameErr = '0;
        for (int k = 0; k < 4; k++) begin
            w_frameErr[k] = (i_frame_in[11*k] != 1'b0)
                         || (i_frame_in[11*k + 10] != 1'b1)
                         || ((^i_frame_in[11*k + 1 +: 9]) != LP_PARITY);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_load && o_ready) begin
                    w_nextState = SHIFT;
                    w_accept    = 1'b1;
                end
            end
            SHIFT: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else if (w_baudWrap && (r_bitCnt == LP_LAST_BIT)) begin
                    if (GUARD_BITS > 0) begin
                        w_nextState = GUARD;
                    end else begin
                        w_nextState = IDLE;
                        w_doneNext  = 1'b1;
                    end
                end
            end
            GUARD: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else if (w_baudWrap && (r_bitCnt == LP_GUARD_LAST)) begin
                    w_nextState = IDLE;
                    w_doneNext  = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The shift register back-fills with ones, so tx idles high once the frame has drained.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '1;
            r_bitCnt   <= '0;
            r_baudCnt  <= '0;
            r_frameErr <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_doneNext;
            if (w_accept) begin
                r_shift    <= i_frame_in;
                r_frameErr <= w_frameErr;
                r_bitCnt   <= '0;
                r_baudCnt  <= '0;
            end else if ((r_state != IDLE) && i_abort) begin
                r_shift   <= '1;
                r_bitCnt  <= '0;
                r_baudCnt <= '0;
            end else if (r_state != IDLE) begin
                if (w_baudWrap) begin
                    r_baudCnt <= '0;
                    r_shift   <= {1'b1, r_shift[43:1]};
                    r_bitCnt  <= (w_nextState != r_state) ? 6'd0 : r_bitCnt + 6'd1;
                end else begin
                    r_baudCnt <= r_baudCnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_serializer.sv
// Directed bench for uart_frame_serializer: instance A (CLK_DIV=4, GUARD_BITS=1), instance B (CLK_DIV=4, GUARD_BITS=0).
module tb_uart_frame_serializer;

    logic        clk;
    logic        rst_n;
    logic [43:0] frameA, frameB;
    logic        loadA, loadB, abortA, abortB;
    logic        readyA, txA, busyA, doneA;
    logic        readyB, txB, busyB, doneB;
    logic [3:0]  errA, errB;

    int compareCount = 0;
    int errorCount   = 0;

    logic [43:0] frmNom;
    logic [43:0] frmErr;
    int          doneAt;
    logic        doneSeen;

    uart_frame_serializer #(.CLK_DIV(4), .GUARD_BITS(1), .PARITY_ODD(0)) dutA (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_in(frameA), .i_load(loadA), .i_abort(abortA),
        .o_ready(readyA), .o_tx(txA), .o_busy(busyA), .o_done(doneA), .o_frame_err(errA)
    );

    uart_frame_serializer #(.CLK_DIV(4), .GUARD_BITS(0), .PARITY_ODD(0)) dutB (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_in(frameB), .i_load(loadB), .i_abort(abortB),
        .o_ready(readyB), .o_tx(txB), .o_busy(busyB), .o_done(doneB), .o_frame_err(errB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic ab, input logic [43:0] frm);
        loadA  = ld;
        abortA = ab;
        frameA = frm;
    endtask

    // Full frame on A: bit-by-bit tx, done timing counted from the cycle load is driven.
    task automatic runFrameA(input logic [43:0] frm, input logic [3:0] expErr, input string tag);
        int at;
        at = 0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, frm);
        #1 checkOutput({tag, "_ready"}, 64'(readyA), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, ~frm);
        checkOutput({tag, "_busy"}, 64'(busyA), 64'd1);
        checkOutput({tag, "_err"}, 64'(errA), 64'(expErr));
        for (int c = 1; c <= 176; c++) begin
            checkOutput($sformatf("%s_tx%0d", tag, c), 64'(txA), 64'(frm[(c - 1) / 4]));
            @(negedge clk);
        end
        for (int c = 177; c <= 400; c++) begin
            if (doneA === 1'b1) begin
                at = c;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_doneAt"}, 64'(at), 64'd181);
        checkOutput({tag, "_readyAtDone"}, 64'(readyA), 64'd1);
        checkOutput({tag, "_txAtDone"}, 64'(txA), 64'd1);
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, 64'(doneA), 64'd0);
    endtask

    initial begin
        frmNom = {4{11'h4AA}};
        frmErr = frmNom;
        frmErr[32] = 1'b0;
        frmErr[9]  = ~frmErr[9];
        rst_n  = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        loadB  = 1'b0;
        abortB = 1'b0;
        frameB = '0;

        // Reset values, then unchanged after release.
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 64'(txA), 64'd1);
        checkOutput("rst_ready", 64'(readyA), 64'd1);
        checkOutput("rst_busy", 64'(busyA), 64'd0);
        checkOutput("rst_done", 64'(doneA), 64'd0);
        checkOutput("rst_err", 64'(errA), 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("post_tx", 64'(txA), 64'd1);
        checkOutput("post_ready", 64'(readyA), 64'd1);
        checkOutput("post_busy", 64'(busyA), 64'd0);
        checkOutput("post_done", 64'(doneA), 64'd0);
        checkOutput("post_err", 64'(errA), 64'd0);

        runFrameA(frmNom, 4'b0000, "nom");
        runFrameA(frmErr, 4'b0101, "errfrm");

        // Abort during bit 20 of a frame with errors; frame_err must survive the abort.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, frmErr);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (81) @(negedge clk);
        checkOutput("abort_txBit20", 64'(txA), 64'(frmErr[20]));
        applyStimulus(1'b0, 1'b1, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        #1;
        checkOutput("abort_tx", 64'(txA), 64'd1);
        checkOutput("abort_busy", 64'(busyA), 64'd0);
        checkOutput("abort_ready", 64'(readyA), 64'd1);
        checkOutput("abort_err", 64'(errA), 64'd5);
        doneSeen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (doneA !== 1'b0) doneSeen = 1'b1;
        end
        checkOutput("abort_noDone", 64'(doneSeen), 64'd0);

        // Abort in IDLE masks ready, so the simultaneous load is dropped.
        applyStimulus(1'b1, 1'b1, frmNom);
        #1 checkOutput("idleAbort_ready", 64'(readyA), 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("idleAbort_busy", 64'(busyA), 64'd0);
        runFrameA(frmNom, 4'b0000, "restart");

        // Back-to-back on B with load held; frame_in changes mid-frame to prove accept-only sampling.
        @(negedge clk);
        loadB  = 1'b1;
        frameB = frmNom;
        @(negedge clk);
        frameB = frmErr;
        checkOutput("b2b_err1", 64'(errB), 64'd0);
        for (int c = 1; c <= 176; c++) begin
            checkOutput($sformatf("b2b_f1_tx%0d", c), 64'(txB), 64'(frmNom[(c - 1) / 4]));
            @(negedge clk);
        end
        checkOutput("b2b_done1", 64'(doneB), 64'd1);
        checkOutput("b2b_ready1", 64'(readyB), 64'd1);
        @(negedge clk);
        loadB = 1'b0;
        checkOutput("b2b_busy2", 64'(busyB), 64'd1);
        checkOutput("b2b_err2", 64'(errB), 64'd5);
        checkOutput("b2b_done1Pulse", 64'(doneB), 64'd0);
        for (int c = 178; c <= 353; c++) begin
            checkOutput($sformatf("b2b_f2_tx%0d", c), 64'(txB), 64'(frmErr[(c - 178) / 4]));
            @(negedge clk);
        end
        checkOutput("b2b_done2", 64'(doneB), 64'd1);
        @(negedge clk);
        checkOutput("b2b_idle", 64'(busyB), 64'd0);

        // Asynchronous reset during bit 30 takes effect before the next clock edge.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, frmErr);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (121) @(negedge clk);
        checkOutput("arst_txBit30", 64'(txA), 64'(frmErr[30]));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_tx", 64'(txA), 64'd1);
        checkOutput("arst_busy", 64'(busyA), 64'd0);
        checkOutput("arst_ready", 64'(readyA), 64'd1);
        checkOutput("arst_err", 64'(errA), 64'd0);
        checkOutput("arst_done", 64'(doneA), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runFrameA(frmErr, 4'b0101, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
